regfile_wb_arbiter: RTL and testbench

REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

---
 rtl/regfile_wb_arbiter.sv | 125 ++++++++++++
 tb/tb_regfile_wb_arbiter.sv | 391 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_wb_arbiter.sv
// Arbitrates ALU and load writebacks onto one register-file write port and tracks pending registers.
// Latency: EX grant to RegWEn is 1 cycle; load accept to RegWEn is at least 2 cycles (FIFO is not bypassed).
// Backpressure: ld_ready drops only when the load FIFO is full; ex_ready is high only in a cycle EX is granted.
module regfile_wb_arbiter #(
   parameter int LD_DEPTH = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        ex_valid,
   input  logic [4:0]  ex_rd,
   input  logic [31:0] ex_data,
   output logic        ex_ready,
   input  logic        ld_valid,
   input  logic [4:0]  ld_rd,
   input  logic [31:0] ld_data,
   output logic        ld_ready,
   input  logic        issue_valid,
   input  logic [4:0]  issue_rd,
   output logic [31:0] busy_mask,
   output logic        RegWEn,
   output logic [4:0]  rd_addr,
   output logic [31:0] rd_data,
   output logic [15:0] ex_stall_cnt
);

   localparam int PW = $clog2(LD_DEPTH);
   localparam int CW = PW + 1;

   typedef enum logic {
      SRC_EX = 1'b0,
      SRC_LD = 1'b1
   } src_t;

   logic [4:0]    fifo_rd   [LD_DEPTH];
   logic [31:0]   fifo_data [LD_DEPTH];
   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;
   logic [CW-1:0] count;
   logic          fifo_empty;
   logic          push;
   logic          pop;
   logic          grant_ex;
   logic          grant_ld;
   logic          conflict;
   logic [4:0]    sel_rd;
   logic [31:0]   sel_data;
   logic [31:0]   busy_next;
   src_t          last_winner;

   // Arbitration: sole candidate wins; on conflict the loser of the previous conflict wins.
   always_comb begin
      fifo_empty = (count == '0);
      ld_ready   = (count != CW'(LD_DEPTH));
      push       = ld_valid && ld_ready;
      conflict   = ex_valid && !fifo_empty;
      grant_ex   = rst_n && ex_valid && (fifo_empty || (last_winner == SRC_LD));
      grant_ld   = !fifo_empty && (!ex_valid || (last_winner == SRC_EX));
      pop        = grant_ld;
      ex_ready   = grant_ex;
      sel_rd     = grant_ld ? fifo_rd[rd_ptr]   : ex_rd;
      sel_data   = grant_ld ? fifo_data[rd_ptr] : ex_data;
   end

   // Load FIFO payload storage; contents are only meaningful while count covers them.
   always_ff @(posedge clk) begin
      if (push) begin
         fifo_rd[wr_ptr]   <= ld_rd;
         fifo_data[wr_ptr] <= ld_data;
      end
   end

   // Load FIFO pointers/occupancy and conflict history; reset discards any queued loads.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         count       <= '0;
         last_winner <= SRC_EX;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         count <= count + CW'(push) - CW'(pop);
         if (conflict) last_winner <= grant_ld ? SRC_LD : SRC_EX;
      end
   end

   // Register the granted request onto the write port; rd 0 completes the handshake silently.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         RegWEn  <= 1'b0;
         rd_addr <= '0;
         rd_data <= '0;
      end else if (grant_ex || grant_ld) begin
         RegWEn  <= (sel_rd != 5'd0);
         rd_addr <= sel_rd;
         rd_data <= sel_data;
      end else begin
         RegWEn  <= 1'b0;
      end
   end

   // Pending-write scoreboard: commit clears, issue sets afterwards so a re-issue wins.
   always_comb begin
      busy_next = busy_mask;
      if (RegWEn) busy_next[rd_addr] = 1'b0;
      if (issue_valid && (issue_rd != 5'd0)) busy_next[issue_rd] = 1'b1;
      busy_next[0] = 1'b0;
   end

   // Pending-write mask register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) busy_mask <= '0;
      else        busy_mask <= busy_next;
   end

   // Saturating count of cycles where EX was presented but not granted.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ex_stall_cnt <= '0;
      end else if (ex_valid && !ex_ready && (ex_stall_cnt != 16'hFFFF)) begin
         ex_stall_cnt <= ex_stall_cnt + 16'd1;
      end
   end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench for regfile_wb_arbiter: scoreboard of expected register writes
// plus per-scenario inline checks of handshakes, busy mask, stall counter and reset.
module tb_regfile_wb_arbiter;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        ex_valid = 1'b0;
   logic [4:0]  ex_rd = '0;
   logic [31:0] ex_data = '0;
   logic        ex_ready;
   logic        ld_valid = 1'b0;
   logic [4:0]  ld_rd = '0;
   logic [31:0] ld_data = '0;
   logic        ld_ready;
   logic        issue_valid = 1'b0;
   logic [4:0]  issue_rd = '0;
   logic [31:0] busy_mask;
   logic        RegWEn;
   logic [4:0]  rd_addr;
   logic [31:0] rd_data;
   logic [15:0] ex_stall_cnt;

   int total = 0;
   int bad   = 0;
   logic [36:0] exp_q[$];
   logic [36:0] mon_e;

   regfile_wb_arbiter #(.LD_DEPTH(2)) dut (
      .clk(clk), .rst_n(rst_n),
      .ex_valid(ex_valid), .ex_rd(ex_rd), .ex_data(ex_data), .ex_ready(ex_ready),
      .ld_valid(ld_valid), .ld_rd(ld_rd), .ld_data(ld_data), .ld_ready(ld_ready),
      .issue_valid(issue_valid), .issue_rd(issue_rd), .busy_mask(busy_mask),
      .RegWEn(RegWEn), .rd_addr(rd_addr), .rd_data(rd_data), .ex_stall_cnt(ex_stall_cnt)
   );

   always #5 clk = ~clk;

   // Every committed write must match the oldest expected write.
   always @(negedge clk) begin
      if (rst_n && RegWEn) begin
         total++;
         if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL unexpected_write got rd=%0d data=%h, expected no write", rd_addr, rd_data);
         end else begin
            mon_e = exp_q.pop_front();
            if ({rd_addr, rd_data} !== mon_e) begin
               bad++;
               $display("FAIL write_order got rd=%0d data=%h, expected rd=%0d data=%h",
                        rd_addr, rd_data, mon_e[36:32], mon_e[31:0]);
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog simulation did not finish, got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drain(input string name);
      for (int i = 0; i < 20 && exp_q.size() != 0; i++) begin
         @(negedge clk);
         #1;
      end
      total++;
      if (exp_q.size() != 0) begin
         bad++;
         $display("FAIL %s_drain got %0d writes outstanding, expected 0", name, exp_q.size());
      end
   endtask

   task automatic apply_reset();
      @(negedge clk);
      rst_n = 1'b0;
      ex_valid = 1'b0; ld_valid = 1'b0; issue_valid = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      exp_q.delete();
   endtask

   task automatic test_reset();
      ex_valid = 1'b1;
      #1 rst_n = 1'b0;
      #2;
      total++;
      if ({RegWEn, rd_addr, rd_data, busy_mask, ex_stall_cnt} !== '0) begin
         bad++;
         $display("FAIL reset_regs got we=%b rd=%0d data=%h busy=%h cnt=%0d, expected all 0",
                  RegWEn, rd_addr, rd_data, busy_mask, ex_stall_cnt);
      end
      total++;
      if ({ld_ready, ex_ready} !== 2'b10) begin
         bad++;
         $display("FAIL reset_ready got ld_ready=%b ex_ready=%b, expected 1 0", ld_ready, ex_ready);
      end
      repeat (2) @(negedge clk);
      total++;
      if (ex_ready !== 1'b0 || ex_stall_cnt !== 16'd0) begin
         bad++;
         $display("FAIL reset_hold got ex_ready=%b cnt=%0d, expected 0 0", ex_ready, ex_stall_cnt);
      end
      ex_valid = 1'b0;
      rst_n = 1'b1;
   endtask

   task automatic test_ex_write();
      step();
      ex_valid = 1'b1; ex_rd = 5'd5; ex_data = 32'hDEADBEEF;
      exp_q.push_back({5'd5, 32'hDEADBEEF});
      @(negedge clk);
      total++;
      if (ex_ready !== 1'b1) begin
         bad++;
         $display("FAIL ex_ready_sole got %b, expected 1", ex_ready);
      end
      step();
      ex_valid = 1'b0;
      @(negedge clk);
      total++;
      if ({RegWEn, rd_addr, rd_data} !== {1'b1, 5'd5, 32'hDEADBEEF}) begin
         bad++;
         $display("FAIL ex_latency got we=%b rd=%0d data=%h, expected 1 5 deadbeef", RegWEn, rd_addr, rd_data);
      end
      step();
      @(negedge clk);
      total++;
      if ({RegWEn, rd_addr, rd_data} !== {1'b0, 5'd5, 32'hDEADBEEF}) begin
         bad++;
         $display("FAIL idle_hold got we=%b rd=%0d data=%h, expected 0 5 deadbeef", RegWEn, rd_addr, rd_data);
      end
      drain("ex_write");
   endtask

   task automatic test_conflict();
      apply_reset();
      step();
      ld_valid = 1'b1; ld_rd = 5'd3; ld_data = 32'h33;
      exp_q.push_back({5'd3, 32'h33});
      step();
      ld_rd = 5'd4; ld_data = 32'h44;
      ex_valid = 1'b1; ex_rd = 5'd7; ex_data = 32'h77;
      exp_q.push_back({5'd7, 32'h77});
      exp_q.push_back({5'd4, 32'h44});
      @(negedge clk);
      total++;
      if (ex_ready !== 1'b0) begin
         bad++;
         $display("FAIL first_conflict_ld got ex_ready=%b, expected 0", ex_ready);
      end
      step();
      ld_valid = 1'b0;
      @(negedge clk);
      total++;
      if (ex_ready !== 1'b1 || ex_stall_cnt !== 16'd1) begin
         bad++;
         $display("FAIL second_conflict_ex got ex_ready=%b cnt=%0d, expected 1 1", ex_ready, ex_stall_cnt);
      end
      step();
      ex_rd = 5'd8; ex_data = 32'h78;
      exp_q.push_back({5'd8, 32'h78});
      @(negedge clk);
      total++;
      if (ex_ready !== 1'b0 || ex_stall_cnt !== 16'd1) begin
         bad++;
         $display("FAIL third_conflict_ld got ex_ready=%b cnt=%0d, expected 0 1", ex_ready, ex_stall_cnt);
      end
      step();
      @(negedge clk);
      total++;
      if (ex_ready !== 1'b1 || ex_stall_cnt !== 16'd2) begin
         bad++;
         $display("FAIL ex_after_drain got ex_ready=%b cnt=%0d, expected 1 2", ex_ready, ex_stall_cnt);
      end
      step();
      ex_valid = 1'b0;
      drain("conflict");
   endtask

   task automatic test_back_to_back();
      apply_reset();
      step();
      ld_valid = 1'b1; ld_rd = 5'd10; ld_data = 32'hA0;
      exp_q.push_back({5'd10, 32'hA0});
      step();
      ld_valid = 1'b0;
      ex_valid = 1'b1; ex_rd = 5'd0; ex_data = 32'h0;
      step();
      ld_valid = 1'b1; ld_rd = 5'd11; ld_data = 32'hA1;
      exp_q.push_back({5'd11, 32'hA1});
      @(negedge clk);
      total++;
      if (ex_ready !== 1'b1) begin
         bad++;
         $display("FAIL b2b_ex_sole got ex_ready=%b, expected 1", ex_ready);
      end
      step();
      ld_rd = 5'd12; ld_data = 32'hA2;
      exp_q.push_back({5'd12, 32'hA2});
      @(negedge clk);
      total++;
      if (ex_ready !== 1'b1) begin
         bad++;
         $display("FAIL b2b_ex_conflict got ex_ready=%b, expected 1", ex_ready);
      end
      step();
      ld_rd = 5'd13; ld_data = 32'hA3;
      @(negedge clk);
      total++;
      if (ld_ready !== 1'b0) begin
         bad++;
         $display("FAIL b2b_full got ld_ready=%b, expected 0", ld_ready);
      end
      step();
      @(negedge clk);
      total++;
      if (ld_ready !== 1'b1) begin
         bad++;
         $display("FAIL b2b_after_pop got ld_ready=%b, expected 1", ld_ready);
      end
      exp_q.push_back({5'd13, 32'hA3});
      step();
      ld_valid = 1'b0; ex_valid = 1'b0;
      drain("back_to_back");
   endtask

   task automatic test_busy();
      step();
      issue_valid = 1'b1; issue_rd = 5'd9;
      step();
      issue_valid = 1'b0;
      @(negedge clk);
      total++;
      if (busy_mask !== 32'h0000_0200) begin
         bad++;
         $display("FAIL busy_set got %h, expected 00000200", busy_mask);
      end
      ex_valid = 1'b1; ex_rd = 5'd9; ex_data = 32'h99;
      exp_q.push_back({5'd9, 32'h99});
      step();
      ex_valid = 1'b0;
      issue_valid = 1'b1; issue_rd = 5'd9;
      step();
      issue_valid = 1'b0;
      @(negedge clk);
      total++;
      if (busy_mask !== 32'h0000_0200) begin
         bad++;
         $display("FAIL busy_set_wins got %h, expected 00000200", busy_mask);
      end
      ex_valid = 1'b1; ex_rd = 5'd9; ex_data = 32'h9A;
      exp_q.push_back({5'd9, 32'h9A});
      step();
      ex_valid = 1'b0;
      step();
      @(negedge clk);
      total++;
      if (busy_mask !== 32'h0) begin
         bad++;
         $display("FAIL busy_clear got %h, expected 00000000", busy_mask);
      end
      drain("busy");
   endtask

   task automatic test_rd_zero();
      step();
      issue_valid = 1'b1; issue_rd = 5'd0;
      step();
      issue_valid = 1'b1; issue_rd = 5'd4;
      @(negedge clk);
      total++;
      if (busy_mask !== 32'h0) begin
         bad++;
         $display("FAIL busy_rd0 got %h, expected 00000000", busy_mask);
      end
      step();
      issue_valid = 1'b0;
      ex_valid = 1'b1; ex_rd = 5'd0; ex_data = 32'h55;
      @(negedge clk);
      total++;
      if (ex_ready !== 1'b1 || busy_mask !== 32'h10) begin
         bad++;
         $display("FAIL rd0_accept got ex_ready=%b busy=%h, expected 1 00000010", ex_ready, busy_mask);
      end
      step();
      ex_valid = 1'b0;
      @(negedge clk);
      total++;
      if (RegWEn !== 1'b0) begin
         bad++;
         $display("FAIL rd0_no_write got RegWEn=%b, expected 0", RegWEn);
      end
      ld_valid = 1'b1; ld_rd = 5'd4; ld_data = 32'h44;
      exp_q.push_back({5'd4, 32'h44});
      step();
      ld_valid = 1'b0;
      @(negedge clk);
      total++;
      if (RegWEn !== 1'b0 || busy_mask !== 32'h10) begin
         bad++;
         $display("FAIL ld_no_bypass got RegWEn=%b busy=%h, expected 0 00000010", RegWEn, busy_mask);
      end
      step();
      @(negedge clk);
      total++;
      if (RegWEn !== 1'b1) begin
         bad++;
         $display("FAIL ld_latency got RegWEn=%b, expected 1", RegWEn);
      end
      step();
      @(negedge clk);
      total++;
      if (busy_mask !== 32'h0) begin
         bad++;
         $display("FAIL ld_commit_clear got %h, expected 00000000", busy_mask);
      end
      drain("rd_zero");
   endtask

   task automatic test_reset_mid();
      apply_reset();
      step();
      ex_valid = 1'b1; ex_rd = 5'd0; ex_data = 32'h0;
      ld_valid = 1'b1; ld_rd = 5'd20; ld_data = 32'hB0;
      issue_valid = 1'b1; issue_rd = 5'd3;
      exp_q.push_back({5'd20, 32'hB0});
      step();
      ld_rd = 5'd21; ld_data = 32'hB1;
      issue_rd = 5'd9;
      step();
      ld_rd = 5'd22; ld_data = 32'hB2;
      issue_valid = 1'b0;
      step();
      ld_valid = 1'b0;
      @(negedge clk);
      total++;
      if (ld_ready !== 1'b0 || busy_mask !== 32'h0000_0208 || ex_stall_cnt !== 16'd1) begin
         bad++;
         $display("FAIL mid_prestate got ld_ready=%b busy=%h cnt=%0d, expected 0 00000208 1",
                  ld_ready, busy_mask, ex_stall_cnt);
      end
      #1 rst_n = 1'b0;
      #1;
      total++;
      if ({RegWEn, rd_addr, rd_data, busy_mask, ex_stall_cnt, ld_ready, ex_ready} !== {86'd0, 2'b10}) begin
         bad++;
         $display("FAIL mid_async got we=%b rd=%0d data=%h busy=%h cnt=%0d ldr=%b exr=%b, expected 0 0 0 0 0 1 0",
                  RegWEn, rd_addr, rd_data, busy_mask, ex_stall_cnt, ld_ready, ex_ready);
      end
      ex_valid = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (3) step();
      @(negedge clk);
      total++;
      if (RegWEn !== 1'b0 || ld_ready !== 1'b1) begin
         bad++;
         $display("FAIL mid_no_write got RegWEn=%b ld_ready=%b, expected 0 1", RegWEn, ld_ready);
      end
      ex_valid = 1'b1; ex_rd = 5'd25; ex_data = 32'hC5;
      exp_q.push_back({5'd25, 32'hC5});
      #1;
      total++;
      if (ex_ready !== 1'b1) begin
         bad++;
         $display("FAIL mid_fifo_empty got ex_ready=%b, expected 1", ex_ready);
      end
      step();
      ex_valid = 1'b0;
      drain("reset_mid");
   endtask

   initial begin
      test_reset();
      test_ex_write();
      test_conflict();
      test_back_to_back();
      test_busy();
      test_rd_zero();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
